// File: rtl/shift_tx_unit_pkg.sv
// Shared definitions for the shift_tx_unit serial transmitter:
// FSM state encoding and the idle line level.
package shift_tx_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/shift_tx_unit_dff_bit.sv
// Single-bit register cell with synchronous active-low reset.
// One cell per bit of the shift register.
module dff_bit (
    input  logic Clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge Clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/shift_tx_unit.sv
// Parallel-in, serial-out transmitter: captures din on start, shifts it out LSB-first.
// Optional feature macro PARITY_BIT_EN appends an even-parity bit after the data.
module shift_tx_unit
    import shift_tx_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       Clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           din,
    output logic                       ready,
    output logic                       busy,
    output logic                       sout,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              load;
    logic              shift_en;

`ifdef PARITY_BIT_EN
    logic parity_q, parity_d;

    // Parity must be taken from din at capture time; shreg is destroyed by shifting.
    always_comb begin
        parity_d = parity_q;
        if (load) begin
            parity_d = ^din;
        end
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_BIT_EN
                    state_d = S_PARITY;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef PARITY_BIT_EN
            S_PARITY: begin
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-cell D mux: load din, shift right with zero fill, or hold.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shreg
            logic shift_in;
            if (gi == WIDTH - 1) begin : g_top
                assign shift_in = 1'b0;
            end else begin : g_mid
                assign shift_in = shreg_q[gi+1];
            end

            assign shreg_d[gi] = load     ? din[gi]  :
                                 shift_en ? shift_in :
                                            shreg_q[gi];

            dff_bit u_bit (
                .Clk (Clk),
                .rst (rst),
                .d   (shreg_d[gi]),
                .q   (shreg_q[gi])
            );
        end
    endgenerate

    always_comb begin
        sout = IDLE_LEVEL;
        case (state_q)
            S_SHIFT:  sout = shreg_q[0];
`ifdef PARITY_BIT_EN
            S_PARITY: sout = parity_q;
`endif
            default:  sout = IDLE_LEVEL;
        endcase
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q == S_SHIFT) || (state_q == S_PARITY);
    assign done    = (state_q == S_DONE);
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_shift_tx_unit.sv
// Directed self-checking bench for shift_tx_unit (WIDTH=8), with or without PARITY_BIT_EN.
module tb_shift_tx_unit;

    localparam int W = 8;
`ifdef PARITY_BIT_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         Clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         ready, busy, sout, done;
    logic [3:0]   bit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    shift_tx_unit #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .ready   (ready),
        .busy    (busy),
        .sout    (sout),
        .done    (done),
        .bit_cnt (bit_cnt)
    );

    always #5 Clk = ~Clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; din = '0;
        tick();
        tick();
        n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (sout !== 1'b1)   begin n_fail++; $display("FAIL reset_sout: got %b want 1", sout); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
        rst = 1'b1;
        tick();
        $display("reset: checked idle state");
    endtask

    task automatic test_basic();
        logic exp_b [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        start = 1'b1; din = 8'hA5;
        tick();
        start = 1'b0; din = 8'h00;
        for (int i = 0; i < W; i++) begin
            n_checks++; if (sout !== exp_b[i]) begin n_fail++; $display("FAIL a5_bit%0d: got %b want %b", i, sout, exp_b[i]); end
            n_checks++; if (bit_cnt !== 4'(i)) begin n_fail++; $display("FAIL a5_cnt%0d: got %0d want %0d", i, bit_cnt, i); end
            n_checks++; if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
                n_fail++; $display("FAIL a5_status%0d: busy=%b done=%b ready=%b want 1 0 0", i, busy, done, ready); end
            tick();
        end
`ifdef PARITY_BIT_EN
        n_checks++; if (sout !== 1'b0) begin n_fail++; $display("FAIL a5_parity: got %b want 0", sout); end
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL a5_parity_status: busy=%b done=%b want 1 0", busy, done); end
        tick();
`endif
        n_checks++; if (done !== 1'b1)   begin n_fail++; $display("FAIL a5_done: got %b want 1", done); end
        n_checks++; if (sout !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL a5_done_status: sout=%b busy=%b ready=%b want 1 0 0", sout, busy, ready); end
        n_checks++; if (bit_cnt !== 4'd8) begin n_fail++; $display("FAIL a5_done_cnt: got %0d want 8", bit_cnt); end
        tick();
        n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL a5_idle: ready=%b done=%b want 1 0", ready, done); end
        n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL a5_idle_cnt: got %0d want 0", bit_cnt); end
        $display("frame din=a5: checked");
    endtask

`ifdef PARITY_BIT_EN
    task automatic test_parity();
        logic exp_b [0:7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        start = 1'b1; din = 8'h07;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            n_checks++; if (sout !== exp_b[i]) begin n_fail++; $display("FAIL p07_bit%0d: got %b want %b", i, sout, exp_b[i]); end
            tick();
        end
        n_checks++; if (sout !== 1'b1) begin n_fail++; $display("FAIL p07_parity: got %b want 1", sout); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL p07_early_done: got %b want 0", done); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL p07_done: got %b want 1", done); end
        tick();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL p07_idle: got %b want 1", ready); end
        $display("frame din=07 with parity: checked");
    endtask
`endif

    task automatic test_start_ignored();
        logic exp_b [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int dones = 0;
        start = 1'b1; din = 8'hA5;
        tick();
        start = 1'b0; din = 8'h00;
        for (int i = 0; i < FL + 4; i++) begin
            if (i == 3) begin start = 1'b1; din = 8'hFF; end
            else begin start = 1'b0; din = 8'h00; end
            if (i < W) begin
                n_checks++; if (sout !== exp_b[i]) begin n_fail++; $display("FAIL ign_bit%0d: got %b want %b", i, sout, exp_b[i]); end
            end
            if (done === 1'b1) dones++;
            tick();
        end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", dones); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ign_idle: got %b want 1", ready); end
        $display("frame din=a5 with ignored start: checked");
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        start = 1'b1; din = 8'hA5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (bit_cnt !== 4'd4) begin n_fail++; $display("FAIL mid_cnt_before: got %0d want 4", bit_cnt); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++; if (sout !== 1'b1)    begin n_fail++; $display("FAIL mid_sout: got %b want 1", sout); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", bit_cnt); end
        n_checks++; if (ready !== 1'b1)   begin n_fail++; $display("FAIL mid_ready: got %b want 1", ready); end
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", dones); end
        $display("reset mid-transfer: checked");
    endtask

    task automatic test_back_to_back();
        logic exp_b [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int dones = 0;
        start = 1'b1; din = 8'h3C;
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < FL + 2; p++) begin
                if (p < W) begin
                    n_checks++; if (sout !== exp_b[p] || busy !== 1'b1) begin
                        n_fail++; $display("FAIL b2b_f%0d_bit%0d: sout=%b busy=%b want %b 1", f, p, sout, busy, exp_b[p]); end
                end else if (p < FL) begin
                    n_checks++; if (sout !== 1'b0 || busy !== 1'b1) begin
                        n_fail++; $display("FAIL b2b_f%0d_parity: sout=%b busy=%b want 0 1", f, sout, busy); end
                end else if (p == FL) begin
                    n_checks++; if (sout !== 1'b1 || done !== 1'b1) begin
                        n_fail++; $display("FAIL b2b_f%0d_done: sout=%b done=%b want 1 1", f, sout, done); end
                end else begin
                    n_checks++; if (sout !== 1'b1 || ready !== 1'b1) begin
                        n_fail++; $display("FAIL b2b_f%0d_idle: sout=%b ready=%b want 1 1", f, sout, ready); end
                end
                if (done === 1'b1) dones++;
                if (f == 2 && p == FL + 1) start = 1'b0;
                tick();
            end
            $display("frame %0d din=3c back-to-back: checked", f);
        end
        n_checks++; if (dones !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", dones); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_final_idle: got %b want 1", ready); end
    endtask

    task automatic test_reset_with_start();
        int waited = 0;
        rst = 1'b0; start = 1'b1; din = 8'hA5;
        tick();
        n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rs_hold1: ready=%b busy=%b want 1 0", ready, busy); end
        tick();
        n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rs_hold2: ready=%b busy=%b want 1 0", ready, busy); end
        rst = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || sout !== 1'b1) begin
            n_fail++; $display("FAIL rs_begin: busy=%b sout=%b want 1 1", busy, sout); end
        while (done !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rs_done_timeout: done=%b after %0d cycles want 1", done, waited); end
        tick();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rs_idle: got %b want 1", ready); end
        $display("reset with start held: checked");
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef PARITY_BIT_EN
        test_parity();
`endif
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_reset_with_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
